// File: rtl/ex_mem_stage_if.sv
// rtl/ex_mem_stage_if.sv - execute-to-memory handshake bundle with upstream/downstream views
interface ex_mem_stage_if #(
   parameter int DATA_W = 32
);
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_pc;
   logic [4:0]        in_opcode;
   logic [4:0]        in_aluop;
   logic [DATA_W-1:0] in_result;
   logic              in_overflow;
   logic [DATA_W-1:0] in_store_data;
   logic [4:0]        in_rd;
   logic              in_we_reg;
   logic              in_mem_we;
   logic              in_mem_re;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_pc;
   logic [DATA_W-1:0] out_result;
   logic [DATA_W-1:0] out_store_data;
   logic [4:0]        out_rd;
   logic              out_we_reg;
   logic              out_mem_we;
   logic              out_mem_re;
   logic              out_exception;
   logic [7:0]        exc_count;

   modport slave (
      input  flush, in_valid, in_pc, in_opcode, in_aluop, in_result, in_overflow,
             in_store_data, in_rd, in_we_reg, in_mem_we, in_mem_re, out_ready,
      output in_ready, out_valid, out_pc, out_result, out_store_data, out_rd,
             out_we_reg, out_mem_we, out_mem_re, out_exception, exc_count
   );

   modport master (
      output flush, in_valid, in_pc, in_opcode, in_aluop, in_result, in_overflow,
             in_store_data, in_rd, in_we_reg, in_mem_we, in_mem_re, out_ready,
      input  in_ready, out_valid, out_pc, out_result, out_store_data, out_rd,
             out_we_reg, out_mem_we, out_mem_re, out_exception, exc_count
   );
endinterface

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - two-entry EX/MEM pipeline buffer with overflow exception rewrite
module ex_mem_stage #(
   parameter int DATA_W = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   ex_mem_stage_if.slave bus
);
   typedef struct packed {
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] result;
      logic [DATA_W-1:0] store_data;
      logic [4:0]        rd;
      logic              we_reg;
      logic              mem_we;
      logic              mem_re;
      logic              exception;
   } entry_t;

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   state_t     state;
   entry_t     head;
   entry_t     tail;
   entry_t     in_ent;
   logic       in_ready_r;
   logic       out_valid_r;
   logic [7:0] exc_cnt;
   logic       rewrite;
   logic       push;
   logic       pop;

   // Overflowing add/addi/sub that would write a register is turned into a trap
   // write of a cause code into r30.
   always_comb begin
      rewrite = bus.in_overflow && bus.in_we_reg &&
                (((bus.in_opcode == 5'b00000) &&
                  ((bus.in_aluop == 5'b00000) || (bus.in_aluop == 5'b00001))) ||
                 (bus.in_opcode == 5'b00101));
      in_ent.pc         = bus.in_pc;
      in_ent.result     = bus.in_result;
      in_ent.store_data = bus.in_store_data;
      in_ent.rd         = bus.in_rd;
      in_ent.we_reg     = bus.in_we_reg;
      in_ent.mem_we     = bus.in_mem_we;
      in_ent.mem_re     = bus.in_mem_re;
      in_ent.exception  = 1'b0;
      if (rewrite) begin
         in_ent.rd        = 5'd30;
         in_ent.we_reg    = 1'b1;
         in_ent.mem_we    = 1'b0;
         in_ent.mem_re    = 1'b0;
         in_ent.exception = 1'b1;
         if (bus.in_opcode == 5'b00101)
            in_ent.result = DATA_W'(2);
         else if (bus.in_aluop == 5'b00000)
            in_ent.result = DATA_W'(1);
         else
            in_ent.result = DATA_W'(3);
      end
   end

   assign push = bus.in_valid && in_ready_r && !bus.flush;
   assign pop  = out_valid_r && bus.out_ready && !bus.flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= EMPTY;
         head        <= '0;
         tail        <= '0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         exc_cnt     <= 8'd0;
      end else begin
         if (push && rewrite && (exc_cnt != 8'hFF))
            exc_cnt <= exc_cnt + 8'd1;
         if (bus.flush) begin
            state       <= EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
         end else begin
            case (state)
               EMPTY: begin
                  if (push) begin
                     head        <= in_ent;
                     state       <= ONE;
                     out_valid_r <= 1'b1;
                  end
               end
               ONE: begin
                  if (push && pop) begin
                     head <= in_ent;
                  end else if (push) begin
                     tail       <= in_ent;
                     state      <= FULL;
                     in_ready_r <= 1'b0;
                  end else if (pop) begin
                     state       <= EMPTY;
                     out_valid_r <= 1'b0;
                  end
               end
               FULL: begin
                  // in_ready is low here, so only a pop can happen
                  if (pop) begin
                     head       <= tail;
                     state      <= ONE;
                     in_ready_r <= 1'b1;
                  end
               end
               default: begin
                  state       <= EMPTY;
                  in_ready_r  <= 1'b1;
                  out_valid_r <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.in_ready       = in_ready_r;
   assign bus.out_valid      = out_valid_r;
   assign bus.out_pc         = out_valid_r ? head.pc         : '0;
   assign bus.out_result     = out_valid_r ? head.result     : '0;
   assign bus.out_store_data = out_valid_r ? head.store_data : '0;
   assign bus.out_rd         = out_valid_r ? head.rd         : 5'd0;
   assign bus.out_we_reg     = out_valid_r && head.we_reg;
   assign bus.out_mem_we     = out_valid_r && head.mem_we;
   assign bus.out_mem_re     = out_valid_r && head.mem_re;
   assign bus.out_exception  = out_valid_r && head.exception;
   assign bus.exc_count      = exc_cnt;
endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 Parameter: DATA_W, 32, width of result, store-data and PC fields.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; low clears all state immediately, independent of clock.
REQ-004 flush  input  1  synchronous discard of all buffered and incoming entries.
REQ-005 in_valid  input  1  upstream execute stage presents an entry.
REQ-006 in_ready  output  1  stage can accept an entry this cycle.
REQ-007 in_pc  input  DATA_W  PC of the instruction.
REQ-008 in_opcode  input  5  instruction opcode field.
REQ-009 in_aluop  input  5  ALU opcode driven to the ALU this instruction.
REQ-010 in_result  input  DATA_W  ALU data_result.
REQ-011 in_overflow  input  1  ALU overflow flag.
REQ-012 in_store_data  input  DATA_W  rd-register data for stores.
REQ-013 in_rd  input  5  destination register index.
REQ-014 in_we_reg, in_mem_we, in_mem_re  input  1 each  register write, memory write, memory read enables.
REQ-015 out_valid  output  1  head entry valid.
REQ-016 out_ready  input  1  downstream memory stage accepts head entry.
REQ-017 out_pc, out_result, out_store_data  output  DATA_W each  head entry fields.
REQ-018 out_rd  output  5; out_we_reg, out_mem_we, out_mem_re, out_exception  output  1 each.
REQ-019 exc_count  output  8  count of accepted overflow exceptions.

Function
REQ-020 Push occurs when in_valid && in_ready && !flush; pop occurs when out_valid && out_ready && !flush.
REQ-021 Storage is a 2-entry FIFO; FSM states EMPTY, ONE, FULL; order strictly first-in first-out.
REQ-022 Transitions: EMPTY+push->ONE; ONE+push-only->FULL; ONE+pop-only->EMPTY; ONE+push+pop->ONE; FULL+pop->ONE; otherwise hold.
REQ-023 in_ready is registered: 1 in EMPTY and ONE, 0 in FULL; no push is possible in FULL.
REQ-024 out_valid is 1 in ONE and FULL, 0 in EMPTY; all out_* data fields are 0 when out_valid is 0.
REQ-025 Latency: entry pushed at edge N appears on outputs after edge N when queue was EMPTY.
REQ-026 Head entry and all its fields hold stable while out_valid && !out_ready.
REQ-027 Exception rewrite applied at push, before storage, when in_overflow=1 and in_we_reg=1:
REQ-028   - in_opcode=00000, in_aluop=00000 (add): rd=30, result=1.
REQ-029   - in_opcode=00101 (addi): rd=30, result=2.
REQ-030   - in_opcode=00000, in_aluop=00001 (sub): rd=30, result=3.
REQ-031 Rewritten entry stores exception=1, we_reg=1, mem_we=0, mem_re=0; other fields pass unchanged.
REQ-032 in_overflow on any other opcode/aluop combination is ignored; entry stored unmodified, exception=0.
REQ-033 exc_count increments by 1 on each push with rewrite applied; saturates at 255, no wrap.
REQ-034 flush=1: next state EMPTY, incoming entry dropped, no pop, exc_count unchanged for the dropped entry; flush overrides push and pop.
REQ-035 in_valid while in_ready=0 is not consumed; upstream must hold the entry.

Reset
REQ-036 reset low: state EMPTY, in_ready=1 after release, out_valid=0, all out_* fields 0, exc_count=0.
REQ-037 reset asserted mid-transfer discards all entries; no partial entry is emitted after release.
REQ-038 First push possible on first rising edge after reset goes high.

Verification
REQ-039 Reset release, in_valid=1 add result 0x0000_0005 rd=4, out_ready=1 -> next cycle out_valid=1, out_result=5, out_rd=4, out_exception=0.
REQ-040 add with in_overflow=1 -> out_rd=30, out_result=1, out_exception=1, exc_count=1; addi -> result 2; sub -> result 3, exc_count=3.
REQ-041 out_ready=0, push 3 entries A,B,C -> in_ready=0 after B, C held; out_ready=1 -> A, B, C emitted in order, one per cycle.
REQ-042 FULL with flush=1 and in_valid=1 -> next cycle out_valid=0, in_ready=1, exc_count unchanged.
REQ-043 256 overflow adds pushed -> exc_count=255 after 255th and after 256th.
REQ-044 reset pulsed low with FULL queue between edges -> out_valid=0 immediately, all outputs 0.
